// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: shared datapath widths and load funct3 encodings
package mem_wb_stage_pkg;
  localparam int DataBusBits = 64;
  localparam int RegAddrBits = 5;
  localparam logic [RegAddrBits-1:0] RegZero = '0;
  localparam logic [2:0] LoadB  = 3'b000;
  localparam logic [2:0] LoadH  = 3'b001;
  localparam logic [2:0] LoadW  = 3'b010;
  localparam logic [2:0] LoadD  = 3'b011;
  localparam logic [2:0] LoadBU = 3'b100;
  localparam logic [2:0] LoadHU = 3'b101;
  localparam logic [2:0] LoadWU = 3'b110;
endpackage

// File: rtl/mem_wb_stage_load_align.sv
// load_align: byte-lane selection, extension and misalignment detection for loads
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DataBusBits
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [2:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data,
  output logic              fault
);
  logic [DATA_W-1:0] sh;
  assign sh = read_data >> {offset, 3'b000};
  // extend the selected lane and flag accesses that cross their natural alignment
  always_comb begin
    data = funct3 == LoadB  ? {{(DATA_W-8){sh[7]}}, sh[7:0]} :
           funct3 == LoadBU ? {{(DATA_W-8){1'b0}}, sh[7:0]} :
           funct3 == LoadH  ? {{(DATA_W-16){sh[15]}}, sh[15:0]} :
           funct3 == LoadHU ? {{(DATA_W-16){1'b0}}, sh[15:0]} :
           funct3 == LoadW  ? {{(DATA_W-32){sh[31]}}, sh[31:0]} :
           funct3 == LoadWU ? {{(DATA_W-32){1'b0}}, sh[31:0]} :
           funct3 == LoadD  ? sh : '0;
    fault = ((funct3 == LoadH || funct3 == LoadHU) && offset[0]) ||
            ((funct3 == LoadW || funct3 == LoadWU) && offset[1:0] != 2'b00) ||
            (funct3 == LoadD && offset != 3'b000) ||
            funct3 == 3'b111;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load formatting and fault capture
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W = DataBusBits,
  parameter int ADDR_W = RegAddrBits
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic              mem_load,
  input  logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_branch_op,
  input  logic              mem_valid_prediction,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_bubble,
  output logic              wb_branch_op,
  output logic              wb_valid_prediction,
  output logic              wb_load_fault
);
  logic [DATA_W-1:0] ld_data;
  logic ld_fault, fault;
  load_align #(.DATA_W(DATA_W)) u_align (
    .read_data(mem_read_data),
    .offset(mem_alu_result[2:0]),
    .funct3(mem_funct3),
    .data(ld_data),
    .fault(ld_fault)
  );
  assign fault = mem_load && ld_fault;
  // reset and flush force a bubble, stall holds, otherwise capture the MEM slot
  always_ff @(posedge clk) begin
    if (reset || flush || (!stall && !mem_valid)) begin
      wb_we <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
      wb_bubble <= 1'b1;
      wb_branch_op <= 1'b0;
      wb_valid_prediction <= 1'b0;
      wb_load_fault <= 1'b0;
    end else if (!stall) begin
      wb_we <= mem_we && mem_rd != RegZero[ADDR_W-1:0] && !fault;
      wb_rd <= mem_rd;
      wb_data <= fault ? '0 : mem_load ? ld_data : mem_alu_result;
      wb_bubble <= 1'b0;
      wb_branch_op <= mem_branch_op;
      wb_valid_prediction <= mem_branch_op && mem_valid_prediction;
      wb_load_fault <= fault;
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed vectors, corner sequences and randomized model check
module tb_mem_wb_stage;
  typedef struct packed {
    logic valid; logic we; logic [4:0] rd; logic [63:0] alu;
    logic load; logic [2:0] f3; logic [63:0] rdata; logic br; logic vp;
  } in_t;
  typedef struct packed {
    logic we; logic [4:0] rd; logic [63:0] data;
    logic bubble; logic br; logic vp; logic fault;
  } out_t;
  typedef struct { in_t i; out_t o; string name; } tv_t;

  logic clk = 0, reset, stall, flush;
  logic mem_valid, mem_we, mem_load, mem_branch_op, mem_valid_prediction;
  logic [4:0] mem_rd;
  logic [63:0] mem_alu_result, mem_read_data;
  logic [2:0] mem_funct3;
  logic wb_we, wb_bubble, wb_branch_op, wb_valid_prediction, wb_load_fault;
  logic [4:0] wb_rd;
  logic [63:0] wb_data;
  int errors = 0, checks = 0;
  int br_cnt = 0, br_held = 0;
  logic st_q = 0;
  out_t exp_o;
  tv_t tv[18];

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_alu_result(mem_alu_result), .mem_load(mem_load), .mem_funct3(mem_funct3),
    .mem_read_data(mem_read_data), .mem_branch_op(mem_branch_op),
    .mem_valid_prediction(mem_valid_prediction),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_bubble(wb_bubble),
    .wb_branch_op(wb_branch_op), .wb_valid_prediction(wb_valid_prediction),
    .wb_load_fault(wb_load_fault)
  );

  // register-file style branch counter: one count per newly written branch, plus held-cycle count
  always @(posedge clk) st_q <= stall;
  always @(negedge clk) begin
    if (wb_branch_op) br_held <= br_held + 1;
    if (wb_branch_op && !st_q) br_cnt <= br_cnt + 1;
  end

  function automatic out_t bubble_o();
    out_t b = '0;
    b.bubble = 1'b1;
    return b;
  endfunction

  // load value from size/sign rules using plain arithmetic on the byte offset
  function automatic logic [63:0] fmt(input logic [63:0] rd_data, input int off, input logic [2:0] f3, output logic flt);
    int sz = 1 << f3[1:0];
    logic [63:0] v = rd_data >> (off * 8);
    logic [63:0] mask;
    flt = (f3 == 3'b111) || (off % sz) != 0;
    if (sz < 8) begin
      mask = (64'd1 << (sz * 8)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[sz*8-1]) v = v | ~mask;
    end
    return v;
  endfunction

  function automatic out_t model(input out_t cur, input in_t i, input logic st, input logic fl, input logic rs);
    out_t n;
    logic f;
    logic [63:0] v;
    if (rs || fl) return bubble_o();
    if (st) return cur;
    if (!i.valid) return bubble_o();
    v = fmt(i.rdata, int'(i.alu[2:0]), i.f3, f);
    f = i.load && f;
    n.fault = f;
    n.bubble = 1'b0;
    n.rd = i.rd;
    n.we = i.we && i.rd != 0 && !f;
    n.data = f ? 64'd0 : (i.load ? v : i.alu);
    n.br = i.br;
    n.vp = i.br && i.vp;
    return n;
  endfunction

  function automatic out_t dut_o();
    return {wb_we, wb_rd, wb_data, wb_bubble, wb_branch_op, wb_valid_prediction, wb_load_fault};
  endfunction

  task automatic check(input string name, input out_t want);
    out_t got = dut_o();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got we=%b rd=%0d data=%h bub=%b br=%b vp=%b flt=%b, want we=%b rd=%0d data=%h bub=%b br=%b vp=%b flt=%b",
        name, got.we, got.rd, got.data, got.bubble, got.br, got.vp, got.fault,
        want.we, want.rd, want.data, want.bubble, want.br, want.vp, want.fault);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // drive one cycle, advance the model, compare 1 time unit after the edge
  task automatic step(input string name, input in_t i, input logic st, input logic fl, input logic rs);
    {mem_valid, mem_we, mem_rd, mem_alu_result, mem_load, mem_funct3, mem_read_data, mem_branch_op, mem_valid_prediction} = i;
    stall = st;
    flush = fl;
    reset = rs;
    @(posedge clk);
    #1;
    exp_o = model(exp_o, i, st, fl, rs);
    check(name, exp_o);
  endtask

  function automatic in_t alu_op(input logic [4:0] rd, input logic [63:0] v, input logic br);
    return '{1'b1, 1'b1, rd, v, 1'b0, 3'b000, 64'd0, br, 1'b1};
  endfunction

  function automatic in_t rand_in();
    in_t i;
    i.valid = $urandom_range(0, 7) != 0;
    i.we = 1'($urandom);
    i.rd = 5'($urandom);
    i.alu = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 1) i.alu[2:0] = 3'b000;
    i.load = 1'($urandom);
    i.f3 = 3'($urandom);
    i.rdata = {$urandom, $urandom};
    i.br = 1'($urandom);
    i.vp = 1'($urandom);
    return i;
  endfunction

  initial begin
    in_t idle = '0;
    exp_o = bubble_o();
    tv[0]  = '{'{1'b1,1'b1,5'd3,64'h1,1'b1,3'b000,64'h8000,1'b0,1'b0}, '{1'b1,5'd3,64'hFFFFFFFFFFFFFF80,1'b0,1'b0,1'b0,1'b0}, "lb_sext"};
    tv[1]  = '{'{1'b1,1'b1,5'd3,64'h1,1'b1,3'b100,64'h8000,1'b0,1'b0}, '{1'b1,5'd3,64'h80,1'b0,1'b0,1'b0,1'b0}, "lbu_zext"};
    tv[2]  = '{'{1'b1,1'b1,5'd4,64'h1002,1'b1,3'b010,64'hFFFF,1'b0,1'b0}, '{1'b0,5'd4,64'h0,1'b0,1'b0,1'b0,1'b1}, "lw_misaligned"};
    tv[3]  = '{'{1'b1,1'b1,5'd7,64'h100,1'b1,3'b011,64'h0123456789ABCDEF,1'b0,1'b0}, '{1'b1,5'd7,64'h0123456789ABCDEF,1'b0,1'b0,1'b0,1'b0}, "ld_full"};
    tv[4]  = '{'{1'b1,1'b1,5'd0,64'h55,1'b0,3'b000,64'h0,1'b0,1'b0}, '{1'b0,5'd0,64'h55,1'b0,1'b0,1'b0,1'b0}, "alu_rd0"};
    tv[5]  = '{'{1'b1,1'b1,5'd5,64'h1234,1'b0,3'b000,64'h0,1'b0,1'b0}, '{1'b1,5'd5,64'h1234,1'b0,1'b0,1'b0,1'b0}, "alu_rd5"};
    tv[6]  = '{'{1'b1,1'b1,5'd9,64'h6,1'b1,3'b001,64'hFFFE000000000000,1'b0,1'b0}, '{1'b1,5'd9,64'hFFFFFFFFFFFFFFFE,1'b0,1'b0,1'b0,1'b0}, "lh_off6"};
    tv[7]  = '{'{1'b1,1'b1,5'd9,64'h6,1'b1,3'b101,64'hFFFE000000000000,1'b0,1'b0}, '{1'b1,5'd9,64'hFFFE,1'b0,1'b0,1'b0,1'b0}, "lhu_off6"};
    tv[8]  = '{'{1'b1,1'b1,5'd10,64'h4,1'b1,3'b010,64'h8000000000000000,1'b0,1'b0}, '{1'b1,5'd10,64'hFFFFFFFF80000000,1'b0,1'b0,1'b0,1'b0}, "lw_off4"};
    tv[9]  = '{'{1'b1,1'b1,5'd10,64'h4,1'b1,3'b110,64'h8000000000000000,1'b0,1'b0}, '{1'b1,5'd10,64'h80000000,1'b0,1'b0,1'b0,1'b0}, "lwu_off4"};
    tv[10] = '{'{1'b1,1'b1,5'd11,64'h0,1'b1,3'b111,64'hFF,1'b0,1'b0}, '{1'b0,5'd11,64'h0,1'b0,1'b0,1'b0,1'b1}, "f3_illegal"};
    tv[11] = '{'{1'b1,1'b1,5'd12,64'hABC1,1'b0,3'b111,64'hFF,1'b0,1'b0}, '{1'b1,5'd12,64'hABC1,1'b0,1'b0,1'b0,1'b0}, "nonload_ignores_f3"};
    tv[12] = '{'{1'b0,1'b1,5'd13,64'h77,1'b1,3'b000,64'h1,1'b1,1'b1}, '{1'b0,5'd0,64'h0,1'b1,1'b0,1'b0,1'b0}, "invalid_bubble"};
    tv[13] = '{'{1'b1,1'b0,5'd1,64'h40,1'b0,3'b000,64'h0,1'b1,1'b1}, '{1'b0,5'd1,64'h40,1'b0,1'b1,1'b1,1'b0}, "branch_vp"};
    tv[14] = '{'{1'b1,1'b1,5'd2,64'h44,1'b0,3'b000,64'h0,1'b0,1'b1}, '{1'b1,5'd2,64'h44,1'b0,1'b0,1'b0,1'b0}, "vp_forced0"};
    tv[15] = '{'{1'b1,1'b1,5'd6,64'h7,1'b1,3'b000,64'h7F00000000000000,1'b0,1'b0}, '{1'b1,5'd6,64'h7F,1'b0,1'b0,1'b0,1'b0}, "lb_off7_pos"};
    tv[16] = '{'{1'b1,1'b1,5'd8,64'h4,1'b1,3'b011,64'h1,1'b0,1'b0}, '{1'b0,5'd8,64'h0,1'b0,1'b0,1'b0,1'b1}, "ld_misaligned"};
    tv[17] = '{'{1'b1,1'b1,5'd8,64'h1,1'b1,3'b101,64'h1,1'b0,1'b0}, '{1'b0,5'd8,64'h0,1'b0,1'b0,1'b0,1'b1}, "lhu_odd"};

    step("reset", idle, 1'b0, 1'b0, 1'b1);
    check("reset_const", bubble_o());
    step("idle_after_reset", idle, 1'b0, 1'b0, 1'b0);
    check("idle_const", bubble_o());

    for (int k = 0; k < 18; k++) begin
      step(tv[k].name, tv[k].i, 1'b0, 1'b0, 1'b0);
      check({tv[k].name, "_table"}, tv[k].o);
    end

    step("pre_branch_bubble", idle, 1'b0, 1'b0, 1'b0);
    br_cnt = 0;
    br_held = 0;
    step("branch_load", alu_op(5'd3, 64'h80, 1'b1), 1'b0, 1'b0, 1'b0);
    step("branch_stall1", alu_op(5'd4, 64'h90, 1'b0), 1'b1, 1'b0, 1'b0);
    step("branch_stall2", alu_op(5'd4, 64'h90, 1'b0), 1'b1, 1'b0, 1'b0);
    step("branch_flush", alu_op(5'd4, 64'h90, 1'b0), 1'b0, 1'b1, 1'b0);
    check("branch_flush_const", bubble_o());
    check_int("branch_held_cycles", br_held, 3);
    check_int("branch_count_once", br_cnt, 1);

    step("load_before_sf", alu_op(5'd7, 64'h11, 1'b0), 1'b0, 1'b0, 1'b0);
    step("stall_and_flush", alu_op(5'd8, 64'h22, 1'b0), 1'b1, 1'b1, 1'b0);
    check("stall_and_flush_const", bubble_o());
    step("load_before_rf", alu_op(5'd7, 64'h33, 1'b1), 1'b0, 1'b0, 1'b0);
    step("reset_and_flush", alu_op(5'd8, 64'h44, 1'b1), 1'b1, 1'b1, 1'b1);
    check("reset_and_flush_const", bubble_o());
    step("load_before_rs", alu_op(5'd9, 64'h55, 1'b0), 1'b0, 1'b0, 1'b0);
    step("hold_before_rs", alu_op(5'd10, 64'h66, 1'b0), 1'b1, 1'b0, 1'b0);
    step("reset_mid_stall", alu_op(5'd10, 64'h66, 1'b0), 1'b1, 1'b0, 1'b1);
    step("resume_after_reset", alu_op(5'd11, 64'h77, 1'b0), 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 400; k++)
      step("random", rand_in(), $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
